countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Microwave cook-time down-counter; the counting-down counterpart of the saturating up-counters in the timing path.
- Holds a BCD mm:ss value loaded from the keypad path and decrements it once per external 1 Hz tick while running.
- Drives heat enable, display digits and the end-of-cook beep; sits between the keypad/door logic and the display/magnetron drivers.

Parameters:
- BEEP_TICKS, 3, number of ticks `beep` stays high in DONE before auto-return to IDLE (1..15).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle enable, one per second.
- load  input  1  one-cycle strobe; capture load_min/load_sec.
- load_min  input  8  BCD minutes, {tens,units}, 00..99.
- load_sec  input  8  BCD seconds, {tens,units}, 00..59.
- start  input  1  one-cycle strobe; begin or resume cooking.
- pause  input  1  one-cycle strobe; suspend cooking.
- cancel  input  1  one-cycle strobe; abort and clear time.
- door_open  input  1  level; high = door open.
- min_bcd  output  8  current minutes, BCD.
- sec_bcd  output  8  current seconds, BCD.
- running  output  1  high in RUNNING.
- heat_en  output  1  running & ~door_open (combinational).
- beep  output  1  high in DONE.
- done_pulse  output  1  one-cycle pulse on entry to DONE.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (clear_n low, async): state IDLE, min_bcd=00, sec_bcd=00; running, beep, done_pulse, load_err all 0; beep counter 0.
- States: IDLE, RUNNING, PAUSED, DONE. All outputs except heat_en are registered.
- Priority within one cycle: cancel > door_open > pause > start > load > tick.
- IDLE:
  - load with valid BCD → time updated next cycle.
  - start with time≠00:00 and door closed → RUNNING.
  - start with time 00:00 or door open → ignored.
- RUNNING:
  - tick → decrement by one second:
    - sec units borrow 0→9;
    - sec tens borrow 0→5;
    - borrow into min units 0→9, then min tens.
  - Decrement that yields 00:00 → DONE in the same update; done_pulse=1 for exactly that next cycle; beep counter cleared.
  - pause or door_open → PAUSED, no decrement that cycle even if tick is high.
  - load → ignored.
- PAUSED:
  - Time frozen; ticks ignored.
  - start with door closed → RUNNING; first decrement on the next tick after entry.
  - Valid load → replaces time; state stays PAUSED.
- DONE:
  - Time stays 00:00; beep=1.
  - Each tick increments the beep counter; on the tick that makes it BEEP_TICKS → IDLE, beep=0.
  - Valid load → IDLE with new time.
  - start, pause → ignored.
- cancel in any state → IDLE, time 00:00 next cycle.
- door_open in DONE → IDLE, beep cleared.
- door_open in IDLE/PAUSED → no state change; blocks start.
- Load validity:
  - Any BCD digit >9, or sec tens >5, → load ignored and load_err pulses one cycle.
  - load in RUNNING → ignored without load_err.
- start and tick in the same cycle from IDLE/PAUSED → enter RUNNING, no decrement that cycle.
- Wrap/underflow impossible: 00:00 is never decremented; max value 99:59.
- Async reset mid-count → immediate return to reset values; no done_pulse.

Test Plan:
- Reset, load 00:05, start, 5 ticks → sec_bcd 04,03,02,01,00; done_pulse once on the 5th tick; beep=1; heat_en=0 after.
- Load 01:00, start, 1 tick → 00:59; load 10:00, start, 1 tick → 09:59 (double borrow).
- RUNNING at 00:30: door_open with tick same cycle → PAUSED, stays 00:30, heat_en=0; start while door open ignored; close door, start, tick → 00:29.
- load_sec=8'h60 or load_min=8'h1A → load_err pulse, time unchanged; start from IDLE at 00:00 → stays IDLE.
- DONE with BEEP_TICKS=3: 3 ticks → beep falls, IDLE; repeat and assert cancel after 1 tick → IDLE immediately, beep=0.
- Drop clear_n mid-count at 02:17 → outputs zero asynchronously (before next edge); release, start → ignored (time 00:00).

Source files
------------

// File: rtl/countdown_timer.sv
// Cook-time down-counter: holds a BCD mm:ss value and decrements it once per
// 1 Hz tick while running. It also drives the heat enable, the display digits
// and the end-of-cook beep.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting; time may be loaded; start begins cooking
// ST_RUNNING | heating; each tick removes one second
// ST_PAUSED  | time frozen by pause/door; start resumes, load replaces time
// ST_DONE    | time reached 00:00; beep until BEEP_TICKS ticks elapse
module countdown_timer #(
   parameter int BEEP_TICKS = 3
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       tick,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       cancel,
   input  logic       door_open,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       running,
   output logic       heat_en,
   output logic       beep,
   output logic       done_pulse,
   output logic       load_err
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_PAUSED  = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   logic [1:0] state_q, state_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic [3:0] beep_cnt_q, beep_cnt_d;
   logic       running_q, running_d;
   logic       beep_q, beep_d;
   logic       done_pulse_q, done_pulse_d;
   logic       load_err_q, load_err_d;

   logic [7:0] dec_min, dec_sec;
   logic       load_valid;
   logic       time_zero;
   logic       start_ok;

   assign load_valid = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                       (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
   assign time_zero  = (min_q == 8'h00) && (sec_q == 8'h00);
   // pause and an open door both outrank start; 00:00 has nothing to cook
   assign start_ok   = start && !door_open && !pause && !time_zero;

   // BCD decrement of mm:ss by one second; never applied to 00:00
   always_comb begin
      dec_min = min_q;
      dec_sec = sec_q;
      if (sec_q[3:0] != 4'd0) begin
         dec_sec[3:0] = sec_q[3:0] - 4'd1;
      end else begin
         dec_sec[3:0] = 4'd9;
         if (sec_q[7:4] != 4'd0) begin
            dec_sec[7:4] = sec_q[7:4] - 4'd1;
         end else begin
            dec_sec[7:4] = 4'd5;
            if (min_q[3:0] != 4'd0) begin
               dec_min[3:0] = min_q[3:0] - 4'd1;
            end else begin
               dec_min[3:0] = 4'd9;
               dec_min[7:4] = min_q[7:4] - 4'd1;
            end
         end
      end
   end

   // next-state and next-output logic, priority cancel > door > pause > start > load > tick
   always_comb begin
      state_d      = state_q;
      min_d        = min_q;
      sec_d        = sec_q;
      beep_cnt_d   = beep_cnt_q;
      done_pulse_d = 1'b0;
      load_err_d   = 1'b0;
      if (cancel) begin
         state_d = ST_IDLE;
         min_d   = 8'h00;
         sec_d   = 8'h00;
      end else begin
         case (state_q)
            ST_IDLE, ST_PAUSED: begin
               if (start_ok) begin
                  state_d = ST_RUNNING;
               end else if (load) begin
                  if (load_valid) begin
                     min_d = load_min;
                     sec_d = load_sec;
                  end else begin
                     load_err_d = 1'b1;
                  end
               end
            end
            ST_RUNNING: begin
               if (door_open || pause) begin
                  state_d = ST_PAUSED;
               end else if (tick) begin
                  min_d = dec_min;
                  sec_d = dec_sec;
                  if ((dec_min == 8'h00) && (dec_sec == 8'h00)) begin
                     state_d      = ST_DONE;
                     done_pulse_d = 1'b1;
                     beep_cnt_d   = 4'd0;
                  end
               end
            end
            default: begin
               if (door_open) begin
                  state_d = ST_IDLE;
               end else if (load) begin
                  if (load_valid) begin
                     state_d = ST_IDLE;
                     min_d   = load_min;
                     sec_d   = load_sec;
                  end else begin
                     load_err_d = 1'b1;
                  end
               end else if (tick) begin
                  beep_cnt_d = beep_cnt_q + 4'd1;
                  if ((beep_cnt_q + 4'd1) == 4'(BEEP_TICKS)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
         endcase
      end
      running_d = (state_d == ST_RUNNING);
      beep_d    = (state_d == ST_DONE);
   end

   // state and registered outputs, cleared asynchronously
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_IDLE;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         beep_cnt_q   <= 4'd0;
         running_q    <= 1'b0;
         beep_q       <= 1'b0;
         done_pulse_q <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         beep_cnt_q   <= beep_cnt_d;
         running_q    <= running_d;
         beep_q       <= beep_d;
         done_pulse_q <= done_pulse_d;
         load_err_q   <= load_err_d;
      end
   end

   assign min_bcd    = min_q;
   assign sec_bcd    = sec_q;
   assign running    = running_q;
   assign beep       = beep_q;
   assign done_pulse = done_pulse_q;
   assign load_err   = load_err_q;
   // door must cut the magnetron without waiting for a clock edge
   assign heat_en    = running_q & ~door_open;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random stimulus, all
// checked every cycle against a reference model that keeps time as a plain
// count of seconds.
module tb_countdown_timer;

   localparam int BEEP_TICKS = 3;

   localparam int M_IDLE    = 0;
   localparam int M_RUNNING = 1;
   localparam int M_PAUSED  = 2;
   localparam int M_DONE    = 3;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       cancel = 1'b0;
   logic       door_open = 1'b0;
   logic [7:0] min_bcd, sec_bcd;
   logic       running, heat_en, beep, done_pulse, load_err;

   int n_checks = 0;
   int n_errors = 0;

   int m_state = M_IDLE;
   int m_time  = 0;
   int m_beeps = 0;
   bit m_done  = 1'b0;
   bit m_err   = 1'b0;

   countdown_timer #(.BEEP_TICKS(BEEP_TICKS)) dut (
      .clock      (clock),
      .clear_n    (clear_n),
      .tick       (tick),
      .load       (load),
      .load_min   (load_min),
      .load_sec   (load_sec),
      .start      (start),
      .pause      (pause),
      .cancel     (cancel),
      .door_open  (door_open),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
      .running    (running),
      .heat_en    (heat_en),
      .beep       (beep),
      .done_pulse (done_pulse),
      .load_err   (load_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int to_bcd(input int n);
      return ((n / 10) * 16) + (n % 10);
   endfunction

   function automatic int digit(input logic [7:0] b, input bit hi);
      return hi ? int'(b[7:4]) : int'(b[3:0]);
   endfunction

   function automatic bit load_ok(input logic [7:0] m, input logic [7:0] s);
      return digit(m, 1) <= 9 && digit(m, 0) <= 9 && digit(s, 1) <= 5 && digit(s, 0) <= 9;
   endfunction

   function automatic int load_secs(input logic [7:0] m, input logic [7:0] s);
      return (digit(m, 1) * 10 + digit(m, 0)) * 60 + digit(s, 1) * 10 + digit(s, 0);
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_time  = 0;
      m_beeps = 0;
      m_done  = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_step();
      m_done = 1'b0;
      m_err  = 1'b0;
      if (cancel) begin
         m_state = M_IDLE;
         m_time  = 0;
      end else if (m_state == M_IDLE || m_state == M_PAUSED) begin
         if (start && !door_open && !pause && m_time != 0) begin
            m_state = M_RUNNING;
         end else if (load) begin
            if (load_ok(load_min, load_sec)) m_time = load_secs(load_min, load_sec);
            else m_err = 1'b1;
         end
      end else if (m_state == M_RUNNING) begin
         if (door_open || pause) begin
            m_state = M_PAUSED;
         end else if (tick) begin
            m_time = m_time - 1;
            if (m_time == 0) begin
               m_state = M_DONE;
               m_done  = 1'b1;
               m_beeps = 0;
            end
         end
      end else begin
         if (door_open) begin
            m_state = M_IDLE;
         end else if (load) begin
            if (load_ok(load_min, load_sec)) begin
               m_state = M_IDLE;
               m_time  = load_secs(load_min, load_sec);
            end else begin
               m_err = 1'b1;
            end
         end else if (tick) begin
            m_beeps++;
            if (m_beeps == BEEP_TICKS) m_state = M_IDLE;
         end
      end
   endtask

   task automatic check_outputs();
      chk("min_bcd", min_bcd, to_bcd(m_time / 60));
      chk("sec_bcd", sec_bcd, to_bcd(m_time % 60));
      chk("running", running, m_state == M_RUNNING);
      chk("beep", beep, m_state == M_DONE);
      chk("done_pulse", done_pulse, m_done);
      chk("load_err", load_err, m_err);
      chk("heat_en", heat_en, m_state == M_RUNNING && !door_open);
   endtask

   task automatic step();
      @(posedge clock);
      if (clear_n) model_step();
      @(negedge clock);
      check_outputs();
      tick   = 1'b0;
      load   = 1'b0;
      start  = 1'b0;
      pause  = 1'b0;
      cancel = 1'b0;
   endtask

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      load = 1'b1;
      load_min = m;
      load_sec = s;
      step();
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      step();
   endtask

   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         step();
      end
   endtask

   initial begin
      model_reset();
      #12;
      check_outputs();
      @(negedge clock);
      clear_n = 1'b1;
      step();

      // 00:05 runs out, beeps for BEEP_TICKS ticks and returns to idle
      do_load(8'h00, 8'h05);
      do_start();
      do_ticks(4);
      chk("t1_sec01", sec_bcd, 8'h01);
      do_ticks(1);
      chk("t1_done_pulse", done_pulse, 1'b1);
      chk("t1_beep", beep, 1'b1);
      step();
      chk("t1_pulse_once", done_pulse, 1'b0);
      do_ticks(3);
      chk("t1_beep_off", beep, 1'b0);

      // borrow chains
      do_load(8'h01, 8'h00);
      do_start();
      do_ticks(1);
      chk("t2_single_borrow", {min_bcd, sec_bcd}, 16'h0059);
      do_cancel();
      do_load(8'h10, 8'h00);
      do_start();
      do_ticks(1);
      chk("t2_double_borrow", {min_bcd, sec_bcd}, 16'h0959);
      do_cancel();

      // door opened while ticking pauses without a decrement
      do_load(8'h00, 8'h31);
      do_start();
      do_ticks(1);
      door_open = 1'b1;
      tick = 1'b1;
      step();
      chk("t3_frozen", sec_bcd, 8'h30);
      do_start();
      chk("t3_start_blocked", running, 1'b0);
      door_open = 1'b0;
      do_start();
      do_ticks(1);
      chk("t3_resumed", sec_bcd, 8'h29);
      do_cancel();

      // rejected loads and start from 00:00
      do_load(8'h00, 8'h60);
      chk("t4_err_sec", load_err, 1'b1);
      do_load(8'h1A, 8'h00);
      chk("t4_err_min", load_err, 1'b1);
      do_start();
      chk("t4_zero_start", running, 1'b0);

      // cancel while beeping
      do_load(8'h00, 8'h01);
      do_start();
      do_ticks(2);
      do_cancel();
      chk("t5_cancel_beep", beep, 1'b0);

      // asynchronous clear mid-count
      do_load(8'h02, 8'h18);
      do_start();
      do_ticks(1);
      #2;
      clear_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clock);
      clear_n = 1'b1;
      do_start();
      chk("t6_start_after_clear", running, 1'b0);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         tick   = ($urandom_range(0, 3) == 0);
         start  = ($urandom_range(0, 9) == 0);
         pause  = ($urandom_range(0, 39) == 0);
         cancel = ($urandom_range(0, 79) == 0);
         load   = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            load_min = 8'($urandom_range(0, 255));
            load_sec = 8'($urandom_range(0, 255));
         end else begin
            load_min = 8'(to_bcd($urandom_range(0, 2)));
            load_sec = 8'(to_bcd($urandom_range(0, 59)));
         end
         if ($urandom_range(0, 49) == 0) door_open = ~door_open;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
